data_memory: RTL

- Word-addressed data memory that responds to load/store requests from the execute stage.
- Samples the execute stage's address, write strobe and store data every cycle.
- Returns load data registered one cycle later, aligned with the cycle in which the execute stage muxes load data into its result.
- After every reset it runs a zero-fill sweep and holds the pipeline stalled until the memory is clean.

---
 rtl/data_memory_pkg.sv | 12 +
 rtl/data_memory_ram.sv | 28 ++
 rtl/data_memory.sv | 99 +++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared widths and FSM encoding for the execute-stage data memory.
// No logic here; constants only.
package data_memory_pkg;

    localparam int ADDR_DEF       = 32;
    localparam int W_OPR_DEF      = 32;
    localparam int DEPTH_LOG2_DEF = 10;

    localparam logic CLEAR = 1'b0;
    localparam logic READY = 1'b1;

endpackage

// File: rtl/data_memory_ram.sv
// Single-port synchronous RAM, write-first registered read, 1-cycle latency.
// en low holds rdata and blocks writes, so the caller stalls it by dropping en.
module dmem_ram #(
    parameter int W_OPR      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [W_OPR-1:0]      wdata,
    output logic [W_OPR-1:0]      rdata
);

    logic [W_OPR-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory: load data one cycle after the address, stores write-first.
// Zero-fills the array after every reset with stall_o high; stall_i freezes loads and blocks stores.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR       = ADDR_DEF,
    parameter int W_OPR      = W_OPR_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDR-1:0]  ldst_addr_i,
    input  logic             ldst_write_i,
    input  logic [W_OPR-1:0] ldst_data_i,
    output logic [W_OPR-1:0] ldst_data_o,
    input  logic             stall_i,
    output logic             stall_o,
    output logic             range_err_o
);

    logic                  state;
    logic [DEPTH_LOG2-1:0] sweep_cnt;
    logic                  in_range;
    logic                  core_go;
    logic                  ram_we;
    logic                  ram_en;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [W_OPR-1:0]      ram_wdata;
    logic [W_OPR-1:0]      ram_rdata;
    logic                  load_vld;

    assign in_range = (ldst_addr_i[ADDR-1:DEPTH_LOG2] == '0);
    assign core_go  = (state == READY) && !stall_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (&sweep_cnt) begin
                state <= READY;
            end
        end
    end

    // The sweep owns the RAM port until READY; the core never reaches it before then.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = ldst_addr_i[DEPTH_LOG2-1:0];
        ram_wdata = ldst_data_i;
        if (state == CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = sweep_cnt;
            ram_wdata = '0;
        end else if (core_go && in_range) begin
            ram_en = 1'b1;
            ram_we = ldst_write_i;
        end
    end

    dmem_ram #(
        .W_OPR      (W_OPR),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .en    (ram_en),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register has no reset, so a resettable qualifier forces
    // zero after reset, during the sweep and after an out-of-range access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_vld <= 1'b0;
        end else if (state == CLEAR) begin
            load_vld <= 1'b0;
        end else if (!stall_i) begin
            load_vld <= in_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_err_o <= 1'b0;
        end else if (core_go && !in_range) begin
            range_err_o <= 1'b1;
        end
    end

    assign ldst_data_o = load_vld ? ram_rdata : '0;
    assign stall_o     = stall_i | (state == CLEAR);

endmodule
